// File: rtl/alu_seq.sv
// alu_seq: sequential, handshaked RV32I integer ALU for the execute stage.
//
// A request is accepted in IDLE when in_valid is high. Operands, op code and
// shift amount are latched, so the inputs may change freely afterwards. Most
// ops produce a registered result one cycle after acceptance. Shifts run in
// an iterative shifter that moves up to SHIFT_STEP bit positions per cycle.
// The result is held in DONE until the consumer takes it with out_ready.
//
// Optional feature macro: ALU_SEQ_MUL_EN
//   When defined, op code 0011 is MUL: the low WIDTH bits of a*b, computed by
//   an unsigned shift-add that handles one bit per cycle. When undefined,
//   0011 is an unrecognised code.
//
// Parameters:
//   WIDTH       operand/result width (power of 2, 8..64)
//   SHIFT_STEP  max bit positions shifted per cycle (power of 2, 1..WIDTH)
//
// Ports:
//   clk        clock, rising edge
//   reset      asynchronous active-high reset
//   in_valid   request valid
//   in_ready   block can accept a request (IDLE only)
//   control    op code {funct3, funct7[5]}
//   data_a     operand A (rs1)
//   data_b     operand B (rs2/imm); shamt = data_b[log2(WIDTH)-1:0]
//   out_valid  result and flags valid
//   out_ready  consumer accepts result
//   result     operation result
//   co         carry out (ADD/SUB only; SUB: 1 = no borrow)
//   ovf        signed overflow (ADD/SUB only)
//   n          result MSB
//   z          result == 0

module alu_seq #(
  parameter int WIDTH      = 32,
  parameter int SHIFT_STEP = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       control,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             co,
  output logic             ovf,
  output logic             n,
  output logic             z
);

  localparam int SHW = $clog2(WIDTH);

  // Step size is held one bit wider than the shift amount so that
  // SHIFT_STEP == WIDTH is representable.
  localparam logic [SHW:0] STEP_C = (SHW+1)'(SHIFT_STEP);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_SLL  = 4'b0010;
  localparam logic [3:0] OP_SLT  = 4'b0100;
  localparam logic [3:0] OP_MOV  = 4'b0101;
  localparam logic [3:0] OP_SLTU = 4'b0110;
  localparam logic [3:0] OP_XOR  = 4'b1000;
  localparam logic [3:0] OP_SRL  = 4'b1010;
  localparam logic [3:0] OP_SRA  = 4'b1011;
  localparam logic [3:0] OP_OR   = 4'b1100;
  localparam logic [3:0] OP_AND  = 4'b1110;

`ifdef ALU_SEQ_MUL_EN
  localparam logic [3:0]   OP_MUL  = 4'b0011;
  localparam logic [SHW:0] MUL_CNT = (SHW+1)'(WIDTH);

  typedef enum logic [2:0] {IDLE, EXEC, SHIFT, MUL, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, EXEC, SHIFT, DONE} state_t;
`endif

  state_t           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [SHW-1:0]   rem_q, rem_d;
  logic             fill_q, fill_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             co_q, co_d;
  logic             ovf_q, ovf_d;
  logic             n_q, n_d;
  logic             z_q, z_d;
`ifdef ALU_SEQ_MUL_EN
  logic [SHW:0]     cnt_q, cnt_d;
`endif

  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   diff_ext;
  logic [WIDTH-1:0] exec_res;
  logic             exec_co;
  logic             exec_ovf;
  logic [SHW:0]     step;
  logic [WIDTH-1:0] fill_mask;
  logic [WIDTH-1:0] shifted;
  logic             is_shift;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = res_q;
  assign co        = co_q;
  assign ovf       = ovf_q;
  assign n         = n_q;
  assign z         = z_q;

  assign is_shift = (control == OP_SLL) || (control == OP_SRL) ||
                    (control == OP_SRA);

  // Single-cycle datapath, evaluated from the latched operands while in EXEC.
  // SUB is a + ~b + 1 so that the carry out reads as "no borrow".
  always_comb begin
    sum_ext  = {1'b0, a_q} + {1'b0, b_q};
    diff_ext = {1'b0, a_q} + {1'b0, ~b_q} + (WIDTH+1)'(1);
    exec_res = '0;
    exec_co  = 1'b0;
    exec_ovf = 1'b0;
    case (op_q)
      OP_ADD: begin
        exec_res = sum_ext[WIDTH-1:0];
        exec_co  = sum_ext[WIDTH];
        exec_ovf = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                   (sum_ext[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SUB: begin
        exec_res = diff_ext[WIDTH-1:0];
        exec_co  = diff_ext[WIDTH];
        exec_ovf = (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                   (diff_ext[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SLT:  exec_res = {{(WIDTH-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
      OP_SLTU: exec_res = {{(WIDTH-1){1'b0}}, (a_q < b_q)};
      OP_MOV:  exec_res = b_q;
      OP_XOR:  exec_res = a_q ^ b_q;
      OP_OR:   exec_res = a_q | b_q;
      OP_AND:  exec_res = a_q & b_q;
      default: exec_res = '0;
    endcase
  end

  // Iterative shifter step: move by min(rem, SHIFT_STEP). SRA fills from the
  // MSB captured at accept time rather than the working register.
  always_comb begin
    step      = ({1'b0, rem_q} < STEP_C) ? {1'b0, rem_q} : STEP_C;
    fill_mask = ~({WIDTH{1'b1}} >> step);
    case (op_q)
      OP_SLL:  shifted = work_q << step;
      OP_SRA:  shifted = (work_q >> step) | (fill_q ? fill_mask : '0);
      default: shifted = work_q >> step;
    endcase
  end

  // Next-state and next-datapath logic. Everything holds by default so the
  // outputs stay stable in DONE under backpressure.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    work_d  = work_q;
    rem_d   = rem_q;
    fill_d  = fill_q;
    res_d   = res_q;
    co_d    = co_q;
    ovf_d   = ovf_q;
`ifdef ALU_SEQ_MUL_EN
    cnt_d   = cnt_q;
`endif

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d   = control;
          a_d    = data_a;
          b_d    = data_b;
          work_d = data_a;
          rem_d  = data_b[SHW-1:0];
          fill_d = data_a[WIDTH-1];
          if (is_shift) begin
            state_d = SHIFT;
`ifdef ALU_SEQ_MUL_EN
          end else if (control == OP_MUL) begin
            work_d  = '0;
            cnt_d   = MUL_CNT;
            state_d = MUL;
`endif
          end else begin
            state_d = EXEC;
          end
        end
      end

      EXEC: begin
        res_d   = exec_res;
        co_d    = exec_co;
        ovf_d   = exec_ovf;
        state_d = DONE;
      end

      SHIFT: begin
        if (rem_q != '0) begin
          work_d = shifted;
          rem_d  = rem_q - step[SHW-1:0];
        end else begin
          res_d   = work_q;
          co_d    = 1'b0;
          ovf_d   = 1'b0;
          state_d = DONE;
        end
      end

`ifdef ALU_SEQ_MUL_EN
      // Shift-add: a_q is the shifting multiplicand, b_q the shifting
      // multiplier, work_q the running product truncated to WIDTH bits.
      MUL: begin
        if (cnt_q != '0) begin
          if (b_q[0]) begin
            work_d = work_q + a_q;
          end
          a_d   = a_q << 1;
          b_d   = b_q >> 1;
          cnt_d = cnt_q - (SHW+1)'(1);
        end else begin
          res_d   = work_q;
          co_d    = 1'b0;
          ovf_d   = 1'b0;
          state_d = DONE;
        end
      end
`endif

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    n_d = res_d[WIDTH-1];
    z_d = (res_d == '0);
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and output registers. Reset leaves z high because the reset
  // result is zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      work_q <= '0;
      rem_q  <= '0;
      fill_q <= 1'b0;
      res_q  <= '0;
      co_q   <= 1'b0;
      ovf_q  <= 1'b0;
      n_q    <= 1'b0;
      z_q    <= 1'b1;
`ifdef ALU_SEQ_MUL_EN
      cnt_q  <= '0;
`endif
    end else begin
      op_q   <= op_d;
      a_q    <= a_d;
      b_q    <= b_d;
      work_q <= work_d;
      rem_q  <= rem_d;
      fill_q <= fill_d;
      res_q  <= res_d;
      co_q   <= co_d;
      ovf_q  <= ovf_d;
      n_q    <= n_d;
      z_q    <= z_d;
`ifdef ALU_SEQ_MUL_EN
      cnt_q  <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: self-checking bench for alu_seq (WIDTH=32, SHIFT_STEP=4).
// Table of directed vectors, hand-written backpressure and reset sequences,
// then randomized ops checked against an arithmetic reference model.

module tb_alu_seq;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   control = 4'd0;
  logic [W-1:0] data_a = '0;
  logic [W-1:0] data_b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic         co, ovf, n, z;

  int pass_count = 0;
  int check_count = 0;

  typedef struct {
    string      name;
    logic [3:0] op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [3:0]  flags;
    int          lat;
  } vec_t;

  vec_t vecs[19];

  alu_seq #(.WIDTH(W), .SHIFT_STEP(4)) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .control(control),
    .data_a(data_a),
    .data_b(data_b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result(result),
    .co(co),
    .ovf(ovf),
    .n(n),
    .z(z)
  );

  always #5 clk = ~clk;

  // Global time limit so the run can never hang.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    check_count++;
    if (act === exp) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model from the op definitions: plain 64-bit arithmetic.
  // Flags are {co, ovf, n, z}.
  function automatic void refModel(input logic [3:0] op, input logic [31:0] a,
                                   input logic [31:0] b, output logic [31:0] r,
                                   output logic [3:0] f, output int lat);
    longint sa, sb, wide;
    int     sh;
    logic   c, v;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    sh  = int'(b % 32);
    r   = '0;
    c   = 1'b0;
    v   = 1'b0;
    lat = 1;
    case (op)
      4'b0000: begin
        r    = a + b;
        c    = (longint'(a) + longint'(b)) > 64'sd4294967295;
        wide = sa + sb;
        v    = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
      end
      4'b0001: begin
        r    = a - b;
        c    = (a >= b);
        wide = sa - sb;
        v    = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
      end
      4'b0010: begin r = a << sh; lat = 1 + (sh + 3) / 4; end
      4'b0100: r = (sa < sb) ? 32'd1 : 32'd0;
      4'b0101: r = b;
      4'b0110: r = (a < b) ? 32'd1 : 32'd0;
      4'b1000: r = a ^ b;
      4'b1010: begin r = a >> sh; lat = 1 + (sh + 3) / 4; end
      4'b1011: begin r = $signed(a) >>> sh; lat = 1 + (sh + 3) / 4; end
      4'b1100: r = a | b;
      4'b1110: r = a & b;
`ifdef ALU_SEQ_MUL_EN
      4'b0011: begin r = 32'(longint'(a) * longint'(b)); lat = 33; end
`endif
      default: r = '0;
    endcase
    f = {c, v, r[31], (r == 32'd0)};
  endfunction

  // Presents one request, scrambles the inputs right after acceptance, and
  // counts rising edges until out_valid is seen (bounded).
  task automatic applyStimulus(input string name, input logic [3:0] op,
                               input logic [31:0] a, input logic [31:0] b,
                               output int lat);
    @(negedge clk);
    checkOutput({name, "_in_ready"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    control  = op;
    data_a   = a;
    data_b   = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    control  = 4'($urandom);
    data_a   = $urandom;
    data_b   = $urandom;
    lat = 0;
    while (lat < 200) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (out_valid) break;
    end
  endtask

  task automatic releaseResult();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic runAndCheck(input string name, input logic [3:0] op,
                             input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] exp_res,
                             input logic [3:0] exp_flags, input int exp_lat);
    int lat;
    applyStimulus(name, op, a, b, lat);
    checkOutput({name, "_latency"}, 64'(lat), 64'(exp_lat));
    checkOutput({name, "_result"}, 64'(result), 64'(exp_res));
    checkOutput({name, "_flags"}, 64'({co, ovf, n, z}), 64'(exp_flags));
    releaseResult();
  endtask

  initial begin
    logic [31:0] ra, rb, mres;
    logic [3:0]  rop, mflags;
    int          mlat, lat;
    logic        spurious;

    // Directed vectors; flags column is {co, ovf, n, z}.
    vecs[0]  = '{"add_ovf",   4'b0000, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b0110, 1};
    vecs[1]  = '{"sub_eq",    4'b0001, 32'h00000005, 32'h00000005, 32'h00000000, 4'b1001, 1};
    vecs[2]  = '{"sub_borrow",4'b0001, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 4'b0010, 1};
    vecs[3]  = '{"sra_31",    4'b1011, 32'h80000000, 32'd31,       32'hFFFFFFFF, 4'b0010, 9};
    vecs[4]  = '{"srl_31",    4'b1010, 32'h80000000, 32'd31,       32'h00000001, 4'b0000, 9};
    vecs[5]  = '{"sll_0",     4'b0010, 32'h12345678, 32'd0,        32'h12345678, 4'b0000, 1};
    vecs[6]  = '{"slt",       4'b0100, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 4'b0000, 1};
    vecs[7]  = '{"sltu",      4'b0110, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b0001, 1};
    vecs[8]  = '{"mov",       4'b0101, 32'h11111111, 32'hDEADBEEF, 32'hDEADBEEF, 4'b0010, 1};
    vecs[9]  = '{"and",       4'b1110, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 4'b0010, 1};
    vecs[10] = '{"or",        4'b1100, 32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0, 4'b0000, 1};
    vecs[11] = '{"unrec_0111",4'b0111, 32'h00000005, 32'h00000007, 32'h00000000, 4'b0001, 1};
`ifdef ALU_SEQ_MUL_EN
    vecs[12] = '{"mul",       4'b0011, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE, 4'b0010, 33};
`else
    vecs[12] = '{"unrec_0011",4'b0011, 32'hFFFFFFFF, 32'h00000002, 32'h00000000, 4'b0001, 1};
`endif
    vecs[13] = '{"sll_4",     4'b0010, 32'h00000001, 32'd4,        32'h00000010, 4'b0000, 2};
    vecs[14] = '{"add_carry", 4'b0000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b1001, 1};
    vecs[15] = '{"sub_ovf",   4'b0001, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 4'b1100, 1};
    vecs[16] = '{"sra_mask",  4'b1011, 32'h40000000, 32'h00000025, 32'h02000000, 4'b0000, 3};
    vecs[17] = '{"xor",       4'b1000, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'hFFFFFFFF, 4'b0010, 1};
    vecs[18] = '{"srl_5",     4'b1010, 32'hF0000000, 32'd5,        32'h07800000, 4'b0000, 3};

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_result", 64'(result), 64'd0);
    checkOutput("rst_flags", 64'({co, ovf, n, z}), 64'b0001);
    @(negedge clk);
    reset = 1'b0;

    $display("[TB] directed vectors");
    for (int i = 0; i < 19; i++) begin
      runAndCheck(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b,
                  vecs[i].res, vecs[i].flags, vecs[i].lat);
    end

    // Backpressure: outputs must stay put while out_ready is low.
    $display("[TB] backpressure sequence");
    applyStimulus("bp", 4'b1000, 32'hF0F0F0F0, 32'h0F0F0F0F, lat);
    checkOutput("bp_latency", 64'(lat), 64'd1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checkOutput("bp_hold_valid", 64'(out_valid), 64'd1);
      checkOutput("bp_hold_result", 64'(result), 64'hFFFFFFFF);
      checkOutput("bp_hold_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    checkOutput("bp_release_valid", 64'(out_valid), 64'd0);
    checkOutput("bp_release_in_ready", 64'(in_ready), 64'd1);

    // Reset in the middle of a long shift.
    $display("[TB] reset during shift");
    @(negedge clk);
    in_valid = 1'b1;
    control  = 4'b0010;
    data_a   = 32'h1;
    data_b   = 32'd20;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("mid_shift_busy", 64'(in_ready), 64'd0);
    reset = 1'b1;
    #1;
    checkOutput("rst2_in_ready", 64'(in_ready), 64'd1);
    checkOutput("rst2_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst2_result", 64'(result), 64'd0);
    checkOutput("rst2_flags", 64'({co, ovf, n, z}), 64'b0001);
    @(negedge clk);
    reset = 1'b0;
    spurious = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      spurious = spurious | out_valid;
    end
    checkOutput("rst2_no_spurious_valid", 64'(spurious), 64'd0);
    runAndCheck("post_rst_add", 4'b0000, 32'd2, 32'd3, 32'd5, 4'b0000, 1);

    // Randomized ops against the reference model.
    $display("[TB] random ops");
    for (int i = 0; i < 80; i++) begin
      rop = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 5))
        0:       ra = 32'h80000000;
        1:       ra = 32'h7FFFFFFF;
        2:       ra = 32'hFFFFFFFF;
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0:       rb = 32'h00000001;
        1:       rb = ra;
        2:       rb = 32'h80000000;
        default: rb = $urandom;
      endcase
      refModel(rop, ra, rb, mres, mflags, mlat);
      runAndCheck($sformatf("rand%0d_op%0h", i, rop), rop, ra, rb,
                  mres, mflags, mlat);
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
